adc_capture_ctrl: RTL
=====================

Name: adc_capture_ctrl

Overview:
Acquisition sequencer between the ADC data receiver and the AXI-Stream master output of the ADC input IP. It arms on a software start, waits for a trigger, and forwards exactly DSIZE 16-bit samples as one AXIS packet with TLAST on the final beat. It can substitute an incrementing test pattern for ADC data, and it reports busy, packet-complete and overflow status to the AXI-lite register block.

Parameters:
DW, 16, sample/TDATA width
CW, 32, width of the size and sample counters

Ports:
ACLK  in  1  single clock; all logic is on this edge
ARESET  in  1  asynchronous, active-high reset
cfg_start  in  1  one-cycle pulse: arm a capture
cfg_abort  in  1  one-cycle pulse: end the capture early
cfg_test  in  1  select test pattern; sampled at start
cfg_dsize  in  CW  samples per packet; sampled at start
cfg_trig_mode  in  2  0=immediate, 1=external edge, 2=level rising, 3=reserved (acts as 0)
cfg_trig_level  in  DW  unsigned threshold for mode 2
ext_trig  in  1  external trigger, already synchronous to ACLK
s_valid  in  1  ADC sample strobe; there is no backpressure
s_data  in  DW  ADC sample
m_tvalid  out  1  AXIS valid
m_tdata  out  DW  AXIS data
m_tkeep  out  DW/8  constant all-ones
m_tlast  out  1  last beat of the packet
m_tready  in  1  AXIS ready
sr_busy  out  1  state is not IDLE
sr_pc  out  1  sticky packet-complete flag
sr_ovf  out  1  sticky flag: a sample was dropped
sample_cnt  out  CW  beats accepted in the current or last capture

Behaviour:
- Reset: state IDLE; m_tvalid, m_tlast, sr_busy, sr_pc, sr_ovf = 0; sample_cnt = 0; m_tdata = 0.
- States: IDLE, WAIT_TRIG, CAPTURE, FLUSH.
- IDLE + cfg_start:
  - Latch dsize, test and trig_mode.
  - Clear sr_pc, sr_ovf and sample_cnt, and reset the test counter to 0.
  - If dsize == 0: set sr_pc and stay in IDLE. No beats are sent.
  - Otherwise go to WAIT_TRIG, or straight to CAPTURE when the latched mode is 0 or 3.
- cfg_start is ignored in any state other than IDLE.
- WAIT_TRIG:
  - Mode 1: the trigger is a rising edge of ext_trig (registered previous value).
  - Mode 2: on an s_valid cycle, the trigger is prev_sample < level and s_data >= level. prev_sample updates only on s_valid, and the first sample after arming has no predecessor, so it cannot trigger.
  - In mode 2, the triggering sample is the first sample of the packet. In mode 1, the first sample is the next s_valid strictly after the edge cycle.
- CAPTURE, on each s_valid cycle:
  - If the output register is free (m_tvalid == 0, or m_tvalid && m_tready this cycle): load m_tdata with the sample (or the test counter), set m_tvalid = 1, and increment the accepted count.
  - m_tlast = 1 when the accepted count reaches the latched dsize. The state then moves to FLUSH.
  - If the output register is not free, the sample is dropped: set sr_ovf, leave the count unchanged. The packet is still exactly dsize beats long.
  - The test counter increments on every s_valid in CAPTURE, dropped or not, so a gap in the pattern reveals the drop.
- Latency: a sample strobed in cycle n appears on m_tvalid/m_tdata in cycle n+1.
- m_tvalid stays high and m_tdata/m_tlast stay stable until m_tready. This is the standard AXIS rule.
- sample_cnt counts beats accepted by the sink (m_tvalid && m_tready).
- FLUSH: wait until the last beat is accepted, then set sr_pc and go to IDLE.
- Abort in WAIT_TRIG: go to IDLE; sr_pc stays 0.
- Abort in CAPTURE:
  - If no beat is pending, go to IDLE with sr_pc = 0.
  - If a beat is pending, force m_tlast = 1 on that beat and go to FLUSH. After it drains, go to IDLE without setting sr_pc.
- Abort and start in the same cycle: abort wins and start is ignored.
- Abort in FLUSH: no effect.
- Counters wrap modulo 2^CW. dsize = 2^CW − 1 is legal.
- Asynchronous reset mid-packet drops any pending beat immediately. The downstream block must be reset together with this one.

Decomposition:
- Package adc_capture_pkg: the state enum, trigger-mode localparams (TRIG_IMM, TRIG_EXT, TRIG_LEVEL), and the DW/CW defaults.
- Sub-module adc_trig_detect: mode decode, ext_trig edge detect, level-crossing compare with prev_sample, and arm/clear. It outputs a one-cycle trig pulse plus a flag saying whether the current sample is included in the packet.

Test Plan:
- Immediate mode, dsize=4, s_valid every cycle, m_tready=1 -> 4 beats; m_tlast only on beat 4; sr_pc=1; sample_cnt=4; each beat one cycle after its sample.
- Test mode, dsize=8, m_tready low for cycles 3-5 -> sr_ovf=1; exactly 8 beats; tdata sequence 0,1,2,... with a gap at the dropped points; m_tdata stable while stalled.
- Level mode, level=0x8000, samples 0x7000,0x7FFF,0x8000,0x9000, dsize=2 -> packet = 0x8000,0x9000.
- External mode: ext_trig edge in cycle 10, samples every cycle -> first beat carries the cycle-11 sample.
- dsize=0 start -> no m_tvalid; sr_pc=1 one cycle later; sr_busy stays 0.
- Abort after 3 beats with a beat held by m_tready=0 -> that beat has m_tlast=1; then IDLE with sr_pc=0. ARESET mid-capture -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture sequencer.
package adc_capture_pkg;

    localparam int DW_DEF = 16;
    localparam int CW_DEF = 32;

    localparam logic [1:0] TRIG_IMM   = 2'd0;
    localparam logic [1:0] TRIG_EXT   = 2'd1;
    localparam logic [1:0] TRIG_LEVEL = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_FLUSH
    } state_e;

endpackage

// File: rtl/adc_trig_detect.sv
// Trigger detection: ext_trig rising edge or rising crossing of a level threshold.
module adc_trig_detect
    import adc_capture_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          arm,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] level,
    input  logic          ext_trig,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          trig,
    output logic          trig_incl
);

    logic          ext_prev_q, ext_prev_d;
    logic [DW-1:0] prev_sample_q, prev_sample_d;
    logic          prev_vld_q, prev_vld_d;
    logic          ext_edge, level_cross;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ext_prev_d    = ext_trig;
        prev_sample_d = prev_sample_q;
        prev_vld_d    = prev_vld_q;
        trig          = 1'b0;
        trig_incl     = 1'b0;

        // The first sample after arming has no predecessor and so cannot trigger.
        if (arm) begin
            prev_vld_d = 1'b0;
        end else if (en && s_valid) begin
            prev_sample_d = s_data;
            prev_vld_d    = 1'b1;
        end

        ext_edge    = ext_trig && !ext_prev_q;
        level_cross = s_valid && prev_vld_q && (prev_sample_q < level) && (s_data >= level);

        if (en) begin
            case (mode)
                TRIG_EXT:   trig = ext_edge;
                TRIG_LEVEL: begin
                    trig      = level_cross;
                    trig_incl = level_cross;
                end
                default:    ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ext_prev_q    <= 1'b0;
            prev_sample_q <= '0;
            prev_vld_q    <= 1'b0;
        end else begin
            ext_prev_q    <= ext_prev_d;
            prev_sample_q <= prev_sample_d;
            prev_vld_q    <= prev_vld_d;
        end
    end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Acquisition sequencer: arm, wait for trigger, emit one DSIZE-beat AXIS packet.
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            cfg_start,
    input  logic            cfg_abort,
    input  logic            cfg_test,
    input  logic [CW-1:0]   cfg_dsize,
    input  logic [1:0]      cfg_trig_mode,
    input  logic [DW-1:0]   cfg_trig_level,
    input  logic            ext_trig,
    input  logic            s_valid,
    input  logic [DW-1:0]   s_data,
    output logic            m_tvalid,
    output logic [DW-1:0]   m_tdata,
    output logic [DW/8-1:0] m_tkeep,
    output logic            m_tlast,
    input  logic            m_tready,
    output logic            sr_busy,
    output logic            sr_pc,
    output logic            sr_ovf,
    output logic [CW-1:0]   sample_cnt
);

    state_e        state_q, state_d;
    logic [CW-1:0] dsize_q, dsize_d;
    logic          test_q, test_d;
    logic [1:0]    mode_q, mode_d;
    logic          aborted_q, aborted_d;
    logic [CW-1:0] load_cnt_q, load_cnt_d;
    logic [DW-1:0] tpat_q, tpat_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic [DW-1:0] m_tdata_q, m_tdata_d;
    logic          m_tlast_q, m_tlast_d;
    logic          sr_pc_q, sr_pc_d;
    logic          sr_ovf_q, sr_ovf_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;

    logic          start_ok, trig, trig_incl, sink_acc, out_free, cap_cycle;
    logic [CW-1:0] load_nxt;

    assign start_ok = (state_q == ST_IDLE) && cfg_start && !cfg_abort;

    adc_trig_detect #(.DW(DW)) u_trig (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .arm       (start_ok),
        .en        (state_q == ST_WAIT_TRIG),
        .mode      (mode_q),
        .level     (cfg_trig_level),
        .ext_trig  (ext_trig),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .trig      (trig),
        .trig_incl (trig_incl)
    );

    always_comb begin
        state_d      = state_q;
        dsize_d      = dsize_q;
        test_d       = test_q;
        mode_d       = mode_q;
        aborted_d    = aborted_q;
        load_cnt_d   = load_cnt_q;
        tpat_d       = tpat_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        sr_pc_d      = sr_pc_q;
        sr_ovf_d     = sr_ovf_q;
        sample_cnt_d = sample_cnt_q;

        sink_acc  = m_tvalid_q && m_tready;
        out_free  = !m_tvalid_q || m_tready;
        load_nxt  = load_cnt_q + CW'(1);
        // A level-mode trigger sample is itself the first beat of the packet.
        cap_cycle = s_valid && !cfg_abort &&
                    ((state_q == ST_CAPTURE) ||
                     (state_q == ST_WAIT_TRIG && trig && trig_incl));

        if (sink_acc) begin
            m_tvalid_d   = 1'b0;
            m_tlast_d    = 1'b0;
            sample_cnt_d = sample_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    dsize_d      = cfg_dsize;
                    test_d       = cfg_test;
                    mode_d       = cfg_trig_mode;
                    aborted_d    = 1'b0;
                    load_cnt_d   = '0;
                    tpat_d       = '0;
                    sr_pc_d      = 1'b0;
                    sr_ovf_d     = 1'b0;
                    sample_cnt_d = '0;
                    if (cfg_dsize == '0)
                        sr_pc_d = 1'b1;
                    else if (cfg_trig_mode == TRIG_EXT || cfg_trig_mode == TRIG_LEVEL)
                        state_d = ST_WAIT_TRIG;
                    else
                        state_d = ST_CAPTURE;
                end
            end
            ST_WAIT_TRIG: begin
                if (cfg_abort)
                    state_d = ST_IDLE;
                else if (trig)
                    state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // A held beat is closed off with TLAST so the sink sees a framed packet.
                if (cfg_abort) begin
                    if (m_tvalid_q && !m_tready) begin
                        m_tlast_d = 1'b1;
                        aborted_d = 1'b1;
                        state_d   = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (sink_acc) begin
                    state_d = ST_IDLE;
                    if (!aborted_q)
                        sr_pc_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The pattern advances on dropped samples too, so drops show as gaps.
        if (cap_cycle) begin
            tpat_d = tpat_q + DW'(1);
            if (out_free) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = test_q ? tpat_q : s_data;
                load_cnt_d = load_nxt;
                m_tlast_d  = (load_nxt == dsize_q);
                state_d    = (load_nxt == dsize_q) ? ST_FLUSH : ST_CAPTURE;
            end else begin
                sr_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            dsize_q      <= '0;
            test_q       <= 1'b0;
            mode_q       <= TRIG_IMM;
            aborted_q    <= 1'b0;
            load_cnt_q   <= '0;
            tpat_q       <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tlast_q    <= 1'b0;
            sr_pc_q      <= 1'b0;
            sr_ovf_q     <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            dsize_q      <= dsize_d;
            test_q       <= test_d;
            mode_q       <= mode_d;
            aborted_q    <= aborted_d;
            load_cnt_q   <= load_cnt_d;
            tpat_q       <= tpat_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            sr_pc_q      <= sr_pc_d;
            sr_ovf_q     <= sr_ovf_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign m_tkeep    = '1;
    assign m_tlast    = m_tlast_q;
    assign sr_busy    = (state_q != ST_IDLE);
    assign sr_pc      = sr_pc_q;
    assign sr_ovf     = sr_ovf_q;
    assign sample_cnt = sample_cnt_q;

endmodule
